param_bank: RTL and testbench
=============================

# param_bank

Parametrised simple-dual-port storage bank: the next-generation bank with configurable data width and depth, bit-masked writes, a registered read port with a valid flag, and a hardware clear sweep that zero-fills the array after reset or on request. Sits between the serial front-end that issues write/read chip-selects and the datapath consumers; one write and one read can be accepted per cycle.

## Interface

- DATA_W, 8, data word width in bits (≥1)
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words
- CLEAR_ON_RESET, 1, 1 = run the zero-fill sweep automatically after reset release; 0 = bank is ready immediately and contents are undefined

- vsi_clk  in  1  single clock; all state updates on its rising edge
- vsi_reset_n  in  1  asynchronous, active-low reset
- vsi_inputData  in  DATA_W  write data
- vsi_inputAddr  in  ADDR_W  write address
- vsi_inputMask  in  DATA_W  per-bit write enable (1 = bit written)
- vsi_inputChipSelect  in  1  write request, sampled each edge
- vsi_outputAddr  in  ADDR_W  read address
- vsi_outputChipSelect  in  1  read request, sampled each edge
- vsi_clear  in  1  synchronous clear request (single-cycle pulse or level)
- vsi_outputData  out  DATA_W  registered read data
- vsi_outputValid  out  1  vsi_outputData holds the result of a read accepted on the previous edge
- vsi_busy  out  1  clear sweep in progress; all requests ignored

## Operation

- Reset (vsi_reset_n=0): vsi_outputData=0, vsi_outputValid=0, sweep counter=0; state=CLEAR and vsi_busy=1 if CLEAR_ON_RESET, else state=READY and vsi_busy=0. Array contents are not reset directly.
- States: READY, CLEAR.
- CLEAR: each edge writes 0 to mem[cnt], cnt++. On the edge that writes DEPTH-1: state→READY, busy→0, cnt→0. Write, read and clear requests in CLEAR are dropped; vsi_outputValid=0; vsi_outputData holds.
- READY, vsi_clear=1: state→CLEAR, busy→1, cnt=0. Write sampled on the same edge is dropped (clear wins). A read sampled on the same edge still completes (valid next cycle, returns pre-clear data).
- READY write: mem[inputAddr] ← (mem & ~inputMask) | (inputData & inputMask). Mask 0 = no change.
- READY read: vsi_outputData ← mem[outputAddr], vsi_outputValid ← 1 on the same edge; otherwise valid ← 0, data holds last value.
- Read and write to the same address on the same edge: write-first; read returns the merged post-write word.
- Address wrap: none needed; all ADDR_W values are legal.
- Reset asserted mid-sweep: sweep aborts asynchronously; after release it restarts from address 0 (if CLEAR_ON_RESET).

## Timing

- Read latency: 1 cycle (request at edge N → data/valid visible after edge N+1's preceding edge, i.e. sampled by consumer at edge N+1).
- Write visible to a read issued on the same edge (bypass) and on any later edge.
- Post-reset sweep: busy=1 for DEPTH edges after reset release; first request accepted on edge DEPTH+1.
- Requested sweep: edge sampling vsi_clear performs no array write; busy=1 for the following DEPTH edges; requests accepted again on the edge after busy falls (DEPTH+1 edges after the clear edge).
- vsi_clear while busy: ignored, sweep not restarted or extended.
- Throughput: one write and one read per cycle in READY.

## Structure

- Package param_bank_pkg: state enum (ST_READY, ST_CLEAR); no width constants (widths are parameters).
- Sub-module param_bank_mem: DEPTH×DATA_W array, masked write port, registered read port with write-first bypass, valid flag. Top-level param_bank holds the FSM, sweep counter, request gating and muxes the sweep write (addr=cnt, data=0, mask=all-ones) onto the write port.

## Test plan

DATA_W=8, ADDR_W=4, CLEAR_ON_RESET=1 unless stated.
- Reset release → busy=1 for exactly 16 edges; reads of all 16 addresses afterwards return 0x00 with valid=1 one cycle after each request.
- Write 0xA5 mask 0xFF @3, then write 0x0F mask 0x0F @3, read @3 → 0xAF, valid=1 next cycle; cycle with no read → valid=0, data holds 0xAF.
- Same-edge write 0x3C mask 0xFF @7 and read @7 → outputData=0x3C next cycle.
- Fill addrs 0–15 with addr×0x11, pulse vsi_clear together with write 0xFF @2 → write dropped, busy=1 for 16 cycles, requests during busy give valid=0, all reads after return 0x00.
- Assert vsi_reset_n low at sweep count 9 for 2 cycles → outputs reset immediately, busy=1 for 16 edges after release.
- CLEAR_ON_RESET=0: busy=0 from reset; write 0x5A @15, read @15 on next edge → 0x5A.

Source files
------------

// File: rtl/param_bank_pkg.sv
// Shared types for the parametrised storage bank.
package param_bank_pkg;

  // Bank controller states: serving requests, or zero-filling the array.
  typedef enum logic [0:0] {
    ST_READY,
    ST_CLEAR
  } bank_state_e;

endpackage

// File: rtl/param_bank_mem.sv
// Simple-dual-port word array with a bit-masked write port and a registered,
// write-first read port carrying a valid flag.
module param_bank_mem #(
  parameter int unsigned DataW = 8,
  parameter int unsigned AddrW = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [AddrW-1:0] wr_addr_i,
  input  logic [DataW-1:0] wr_data_i,
  input  logic [DataW-1:0] wr_mask_i,
  input  logic             rd_en_i,
  input  logic [AddrW-1:0] rd_addr_i,
  output logic [DataW-1:0] rd_data_o,
  output logic             rd_valid_o
);

  localparam int unsigned Depth = 2 ** AddrW;

  logic [DataW-1:0] mem_q [Depth];
  logic [DataW-1:0] wr_merged;
  logic [DataW-1:0] rd_word;
  logic [DataW-1:0] rd_data_q;
  logic             rd_valid_q;

  // Merge the masked write into the stored word; a same-address read sees the merged word.
  always_comb begin
    wr_merged = (mem_q[wr_addr_i] & ~wr_mask_i) | (wr_data_i & wr_mask_i);
    rd_word   = mem_q[rd_addr_i];
    if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
      rd_word = wr_merged;
    end
  end

  // Array storage is deliberately not reset; the controller's sweep initialises it.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_merged;
    end
  end

  // Read register: data holds between reads, valid marks a read accepted on the last edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en_i;
      if (rd_en_i) begin
        rd_data_q <= rd_word;
      end
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/param_bank.sv
// Storage bank top: clear-sweep controller, request gating and the write-port
// mux between the front-end and the zero-fill sweep.
module param_bank
  import param_bank_pkg::*;
#(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned ADDR_W         = 4,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic              vsi_clk,
  input  logic              vsi_reset_n,
  input  logic [DATA_W-1:0] vsi_inputData,
  input  logic [ADDR_W-1:0] vsi_inputAddr,
  input  logic [DATA_W-1:0] vsi_inputMask,
  input  logic              vsi_inputChipSelect,
  input  logic [ADDR_W-1:0] vsi_outputAddr,
  input  logic              vsi_outputChipSelect,
  input  logic              vsi_clear,
  output logic [DATA_W-1:0] vsi_outputData,
  output logic              vsi_outputValid,
  output logic              vsi_busy
);

  localparam logic [ADDR_W-1:0] LastAddr   = '1;
  localparam bank_state_e       ResetState = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
  localparam logic              ResetBusy  = (CLEAR_ON_RESET != 0);

  bank_state_e       state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              busy_q;

  logic              sweeping;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic [DATA_W-1:0] mem_wr_mask;
  logic              mem_rd_en;

  // Controller FSM: sweep counter walks every address once, then hands back to READY.
  always_ff @(posedge vsi_clk or negedge vsi_reset_n) begin
    if (!vsi_reset_n) begin
      state_q <= ResetState;
      busy_q  <= ResetBusy;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        ST_READY: begin
          if (vsi_clear) begin
            state_q <= ST_CLEAR;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        ST_CLEAR: begin
          if (cnt_q == LastAddr) begin
            state_q <= ST_READY;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + ADDR_W'(1);
          end
        end
        default: begin
          state_q <= ST_READY;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Port mux: the sweep owns the write port; a clear request drops a same-edge write
  // but lets a same-edge read complete with pre-clear data.
  always_comb begin
    sweeping    = (state_q == ST_CLEAR);
    mem_wr_en   = vsi_inputChipSelect & ~vsi_clear;
    mem_wr_addr = vsi_inputAddr;
    mem_wr_data = vsi_inputData;
    mem_wr_mask = vsi_inputMask;
    mem_rd_en   = vsi_outputChipSelect & ~sweeping;
    if (sweeping) begin
      mem_wr_en   = 1'b1;
      mem_wr_addr = cnt_q;
      mem_wr_data = '0;
      mem_wr_mask = '1;
    end
  end

  param_bank_mem #(
    .DataW (DATA_W),
    .AddrW (ADDR_W)
  ) u_mem (
    .clk_i      (vsi_clk),
    .rst_ni     (vsi_reset_n),
    .wr_en_i    (mem_wr_en),
    .wr_addr_i  (mem_wr_addr),
    .wr_data_i  (mem_wr_data),
    .wr_mask_i  (mem_wr_mask),
    .rd_en_i    (mem_rd_en),
    .rd_addr_i  (mem_rd_addr_sel(vsi_outputAddr)),
    .rd_data_o  (vsi_outputData),
    .rd_valid_o (vsi_outputValid)
  );

  // Read address passes straight through; wrapped for symmetry with the write mux.
  function automatic logic [ADDR_W-1:0] mem_rd_addr_sel(input logic [ADDR_W-1:0] addr);
    return addr;
  endfunction

  assign vsi_busy = busy_q;

endmodule

// File: tb/tb_param_bank.sv
// Self-checking bench for param_bank: randomised traffic against a word-array model.
module tb_param_bank;

  localparam int Depth = 16;

  logic       vsi_clk = 1'b0;
  logic       vsi_reset_n = 1'b0;
  logic [7:0] vsi_inputData = '0;
  logic [3:0] vsi_inputAddr = '0;
  logic [7:0] vsi_inputMask = '0;
  logic       vsi_inputChipSelect = 1'b0;
  logic [3:0] vsi_outputAddr = '0;
  logic       vsi_outputChipSelect = 1'b0;
  logic       vsi_clear = 1'b0;
  logic [7:0] vsi_outputData;
  logic       vsi_outputValid;
  logic       vsi_busy;

  // Second instance without the automatic post-reset sweep.
  logic       nc_reset_n = 1'b0;
  logic [7:0] nc_inputData = '0;
  logic [3:0] nc_inputAddr = '0;
  logic [7:0] nc_inputMask = '0;
  logic       nc_inputChipSelect = 1'b0;
  logic [3:0] nc_outputAddr = '0;
  logic       nc_outputChipSelect = 1'b0;
  logic       nc_clear = 1'b0;
  logic [7:0] nc_outputData;
  logic       nc_outputValid;
  logic       nc_busy;

  int checks = 0;
  int failures = 0;

  // Reference model: plain word array plus the number of sweep edges still owed.
  logic [7:0] mem_m [Depth];
  int         sweep_left = 0;
  logic [7:0] exp_data = '0;
  logic       exp_valid = 1'b0;
  logic       exp_busy = 1'b1;

  always #5 vsi_clk = ~vsi_clk;

  param_bank #(
    .DATA_W         (8),
    .ADDR_W         (4),
    .CLEAR_ON_RESET (1)
  ) u_dut (
    .vsi_clk              (vsi_clk),
    .vsi_reset_n          (vsi_reset_n),
    .vsi_inputData        (vsi_inputData),
    .vsi_inputAddr        (vsi_inputAddr),
    .vsi_inputMask        (vsi_inputMask),
    .vsi_inputChipSelect  (vsi_inputChipSelect),
    .vsi_outputAddr       (vsi_outputAddr),
    .vsi_outputChipSelect (vsi_outputChipSelect),
    .vsi_clear            (vsi_clear),
    .vsi_outputData       (vsi_outputData),
    .vsi_outputValid      (vsi_outputValid),
    .vsi_busy             (vsi_busy)
  );

  param_bank #(
    .DATA_W         (8),
    .ADDR_W         (4),
    .CLEAR_ON_RESET (0)
  ) u_nc (
    .vsi_clk              (vsi_clk),
    .vsi_reset_n          (nc_reset_n),
    .vsi_inputData        (nc_inputData),
    .vsi_inputAddr        (nc_inputAddr),
    .vsi_inputMask        (nc_inputMask),
    .vsi_inputChipSelect  (nc_inputChipSelect),
    .vsi_outputAddr       (nc_outputAddr),
    .vsi_outputChipSelect (nc_outputChipSelect),
    .vsi_clear            (nc_clear),
    .vsi_outputData       (nc_outputData),
    .vsi_outputValid      (nc_outputValid),
    .vsi_busy             (nc_busy)
  );

  // Drive one cycle of requests, advance the model by one edge, sample 1 time unit after it.
  task automatic step(input logic wcs, input logic [3:0] wa, input logic [7:0] wd,
                      input logic [7:0] wm, input logic rcs, input logic [3:0] ra,
                      input logic clr);
    vsi_inputChipSelect  = wcs;
    vsi_inputAddr        = wa;
    vsi_inputData        = wd;
    vsi_inputMask        = wm;
    vsi_outputChipSelect = rcs;
    vsi_outputAddr       = ra;
    vsi_clear            = clr;
    if (sweep_left > 0) begin
      mem_m[Depth - sweep_left] = 8'h00;
      sweep_left--;
      exp_valid = 1'b0;
    end else begin
      if (clr) sweep_left = Depth;
      else if (wcs) mem_m[wa] = (mem_m[wa] & ~wm) | (wd & wm);
      exp_valid = rcs;
      if (rcs) exp_data = mem_m[ra];
    end
    exp_busy = (sweep_left > 0);
    @(posedge vsi_clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic test_no_clear_on_reset();
    #2;
    checks++;
    if (nc_busy !== 1'b0 || nc_outputValid !== 1'b0 || nc_outputData !== 8'h00) begin
      failures++;
      $display("FAIL nc_reset: busy=%b valid=%b data=%h, want 0 0 00",
               nc_busy, nc_outputValid, nc_outputData);
    end
    @(posedge vsi_clk);
    #1;
    nc_reset_n = 1'b1;
    nc_inputChipSelect = 1'b1;
    nc_inputAddr = 4'd15;
    nc_inputData = 8'h5A;
    nc_inputMask = 8'hFF;
    @(posedge vsi_clk);
    #1;
    checks++;
    if (nc_busy !== 1'b0 || nc_outputValid !== 1'b0) begin
      failures++;
      $display("FAIL nc_write: busy=%b valid=%b, want 0 0", nc_busy, nc_outputValid);
    end
    nc_inputChipSelect = 1'b0;
    nc_outputChipSelect = 1'b1;
    nc_outputAddr = 4'd15;
    @(posedge vsi_clk);
    #1;
    nc_outputChipSelect = 1'b0;
    checks++;
    if (nc_outputData !== 8'h5A || nc_outputValid !== 1'b1) begin
      failures++;
      $display("FAIL nc_read: data=%h valid=%b, want 5a 1", nc_outputData, nc_outputValid);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (vsi_busy !== 1'b1 || vsi_outputValid !== 1'b0 || vsi_outputData !== 8'h00) begin
      failures++;
      $display("FAIL reset: busy=%b valid=%b data=%h, want 1 0 00",
               vsi_busy, vsi_outputValid, vsi_outputData);
    end
    for (int i = 0; i < Depth; i++) mem_m[i] = 8'hxx;
    vsi_reset_n = 1'b1;
    sweep_left = Depth;
    exp_busy = 1'b1;
  endtask

  task automatic test_init_sweep();
    for (int k = 1; k <= Depth; k++) begin
      step(1'b1, 4'(k), 8'hFF, 8'hFF, 1'b1, 4'(k), 1'b1);
      checks++;
      if (vsi_busy !== (k < Depth) || vsi_outputValid !== 1'b0) begin
        failures++;
        $display("FAIL init_sweep edge %0d: busy=%b valid=%b, want %b 0",
                 k, vsi_busy, vsi_outputValid, k < Depth);
      end
    end
    for (int a = 0; a < Depth; a++) begin
      step(1'b0, 4'h0, 8'h00, 8'h00, 1'b1, 4'(a), 1'b0);
      checks++;
      if (vsi_outputData !== 8'h00 || vsi_outputValid !== 1'b1) begin
        failures++;
        $display("FAIL init_read addr %0d: data=%h valid=%b, want 00 1",
                 a, vsi_outputData, vsi_outputValid);
      end
    end
  endtask

  task automatic test_masked_write();
    step(1'b1, 4'd3, 8'hA5, 8'hFF, 1'b0, 4'd0, 1'b0);
    step(1'b1, 4'd3, 8'h0F, 8'h0F, 1'b0, 4'd0, 1'b0);
    step(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'd3, 1'b0);
    checks++;
    if (vsi_outputData !== 8'hAF || vsi_outputValid !== 1'b1) begin
      failures++;
      $display("FAIL masked_read: data=%h valid=%b, want af 1", vsi_outputData, vsi_outputValid);
    end
    idle();
    checks++;
    if (vsi_outputData !== 8'hAF || vsi_outputValid !== 1'b0) begin
      failures++;
      $display("FAIL masked_hold: data=%h valid=%b, want af 0", vsi_outputData, vsi_outputValid);
    end
    step(1'b1, 4'd3, 8'h00, 8'h00, 1'b1, 4'd3, 1'b0);
    checks++;
    if (vsi_outputData !== 8'hAF) begin
      failures++;
      $display("FAIL mask_zero: data=%h, want af", vsi_outputData);
    end
  endtask

  task automatic test_bypass();
    step(1'b1, 4'd7, 8'h3C, 8'hFF, 1'b1, 4'd7, 1'b0);
    checks++;
    if (vsi_outputData !== 8'h3C || vsi_outputValid !== 1'b1) begin
      failures++;
      $display("FAIL bypass: data=%h valid=%b, want 3c 1", vsi_outputData, vsi_outputValid);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom), 8'($urandom),
           1'($urandom_range(0, 1)), 4'($urandom), ($urandom_range(0, 39) == 0));
      checks++;
      if (vsi_busy !== exp_busy || vsi_outputValid !== exp_valid ||
          vsi_outputData !== exp_data) begin
        failures++;
        $display("FAIL random %0d: busy=%b valid=%b data=%h, want %b %b %h", n,
                 vsi_busy, vsi_outputValid, vsi_outputData, exp_busy, exp_valid, exp_data);
      end
    end
    while (sweep_left > 0) idle();
  endtask

  task automatic test_clear();
    for (int a = 0; a < Depth; a++) step(1'b1, 4'(a), 8'(a * 8'h11), 8'hFF, 1'b0, 4'h0, 1'b0);
    step(1'b1, 4'd2, 8'hFF, 8'hFF, 1'b1, 4'd2, 1'b1);
    checks++;
    if (vsi_outputData !== 8'h22 || vsi_outputValid !== 1'b1 || vsi_busy !== 1'b1) begin
      failures++;
      $display("FAIL clear_edge: data=%h valid=%b busy=%b, want 22 1 1",
               vsi_outputData, vsi_outputValid, vsi_busy);
    end
    for (int k = 1; k <= Depth; k++) begin
      step(1'b1, 4'($urandom), 8'hFF, 8'hFF, 1'b1, 4'($urandom), 1'($urandom_range(0, 1)));
      checks++;
      if (vsi_busy !== (k < Depth) || vsi_outputValid !== 1'b0 || vsi_outputData !== 8'h22) begin
        failures++;
        $display("FAIL clear_busy edge %0d: busy=%b valid=%b data=%h, want %b 0 22",
                 k, vsi_busy, vsi_outputValid, vsi_outputData, k < Depth);
      end
    end
    for (int a = 0; a < Depth; a++) begin
      step(1'b0, 4'h0, 8'h00, 8'h00, 1'b1, 4'(a), 1'b0);
      checks++;
      if (vsi_outputData !== 8'h00 || vsi_outputValid !== 1'b1) begin
        failures++;
        $display("FAIL clear_read addr %0d: data=%h valid=%b, want 00 1",
                 a, vsi_outputData, vsi_outputValid);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    step(1'b1, 4'd5, 8'h77, 8'hFF, 1'b0, 4'h0, 1'b0);
    step(1'b0, 4'h0, 8'h00, 8'h00, 1'b1, 4'd5, 1'b1);
    for (int k = 0; k < 9; k++) idle();
    checks++;
    if (vsi_outputData !== 8'h77 || vsi_busy !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset: data=%h busy=%b, want 77 1", vsi_outputData, vsi_busy);
    end
    vsi_reset_n = 1'b0;
    #1;
    checks++;
    if (vsi_outputData !== 8'h00 || vsi_outputValid !== 1'b0 || vsi_busy !== 1'b1) begin
      failures++;
      $display("FAIL async_reset: data=%h valid=%b busy=%b, want 00 0 1",
               vsi_outputData, vsi_outputValid, vsi_busy);
    end
    @(posedge vsi_clk);
    @(posedge vsi_clk);
    #1;
    vsi_reset_n = 1'b1;
    sweep_left = Depth;
    exp_data = 8'h00;
    exp_valid = 1'b0;
    for (int k = 1; k <= Depth; k++) begin
      step(1'b1, 4'd9, 8'hEE, 8'hFF, 1'b1, 4'd9, 1'b0);
      checks++;
      if (vsi_busy !== (k < Depth) || vsi_outputValid !== 1'b0) begin
        failures++;
        $display("FAIL restart_sweep edge %0d: busy=%b valid=%b, want %b 0",
                 k, vsi_busy, vsi_outputValid, k < Depth);
      end
    end
    for (int a = 0; a < Depth; a++) begin
      step(1'b0, 4'h0, 8'h00, 8'h00, 1'b1, 4'(a), 1'b0);
      checks++;
      if (vsi_outputData !== 8'h00 || vsi_outputValid !== 1'b1) begin
        failures++;
        $display("FAIL restart_read addr %0d: data=%h valid=%b, want 00 1",
                 a, vsi_outputData, vsi_outputValid);
      end
    end
  endtask

  initial begin
    test_no_clear_on_reset();
    test_reset();
    test_init_sweep();
    test_masked_write();
    test_bypass();
    test_random();
    test_clear();
    test_reset_mid_sweep();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
